// File: rtl/comb_sweep_ctrl.sv
// Exhaustive truth-table sweep of a 3-input combinational circuit.
// Drives abc 0..7, samples y after a settle delay, compares to EXPECTED.
module comb_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  EXPECTED      = 8'h12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic [2:0] abc,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic [3:0] mismatch_count,
    output logic [2:0] first_fail,
    output logic       pass
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_settle;
    logic [2:0] r_abc;
    logic [7:0] r_result;
    logic [3:0] r_mis;
    logic [2:0] r_ff;
    logic       r_pass;

    logic       w_settle_done;
    logic       w_miss;
    logic       w_last;
    logic [3:0] w_mis_next;

    assign w_settle_done = (r_settle == 4'(SETTLE_CYCLES - 1));
    assign w_miss        = (y != EXPECTED[r_abc]);
    assign w_last        = (r_abc == 3'd7);
    assign w_mis_next    = r_mis + {3'b000, w_miss};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SETTLE;
            SETTLE:  if (w_settle_done) w_next = SAMPLE;
            SAMPLE:  w_next = w_last ? FINISH : SETTLE;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            SETTLE:  busy = 1'b1;
            SAMPLE:  busy = 1'b1;
            FINISH:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // pass is resolved on the final sample edge so it is valid during FINISH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_settle <= '0;
            r_abc    <= '0;
            r_result <= '0;
            r_mis    <= '0;
            r_ff     <= '0;
            r_pass   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_settle <= '0;
                        r_abc    <= '0;
                        r_result <= '0;
                        r_mis    <= '0;
                        r_ff     <= '0;
                        r_pass   <= 1'b0;
                    end
                end
                SETTLE: begin
                    r_settle <= w_settle_done ? 4'd0 : r_settle + 4'd1;
                end
                SAMPLE: begin
                    r_result[r_abc] <= y;
                    r_mis           <= w_mis_next;
                    if (w_miss && (r_mis == 4'd0)) begin
                        r_ff <= r_abc;
                    end
                    if (w_last) begin
                        r_pass <= (w_mis_next == 4'd0);
                    end else begin
                        r_abc <= r_abc + 3'd1;
                    end
                end
                default: begin
                    r_settle <= r_settle;
                end
            endcase
        end
    end

    assign abc            = r_abc;
    assign result         = r_result;
    assign mismatch_count = r_mis;
    assign first_fail     = r_ff;
    assign pass           = r_pass;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: two instances (settle 1 and 3) against
// an elapsed-edge arithmetic model, plus directed literal expectations.
module tb_comb_sweep_ctrl;

    localparam logic [7:0] GOLD = 8'h12;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tbl [2] = '{8'h12, 8'h12};
    logic [7:0] exp_tt  = 8'h12;

    logic       y      [2];
    logic [2:0] abc    [2];
    logic       busy   [2];
    logic       done   [2];
    logic [7:0] res    [2];
    logic [3:0] mc     [2];
    logic [2:0] ff     [2];
    logic       pass_o [2];

    int errors = 0;
    int checks = 0;
    int hold [8];

    bit         m_act  [2] = '{0, 0};
    int         m_e    [2] = '{0, 0};
    logic [2:0] m_abc  [2] = '{0, 0};
    logic [7:0] m_res  [2] = '{0, 0};
    logic [3:0] m_cnt  [2] = '{0, 0};
    logic [2:0] m_ff   [2] = '{0, 0};
    logic       m_pass [2] = '{0, 0};

    always #5 clk = ~clk;

    assign y[0] = tbl[0][abc[0]];
    assign y[1] = tbl[1][abc[1]];

    comb_sweep_ctrl #(.SETTLE_CYCLES(1), .EXPECTED(GOLD)) u0 (
        .clk(clk), .rst(rst), .start(start), .y(y[0]),
        .abc(abc[0]), .busy(busy[0]), .done(done[0]),
        .result(res[0]), .mismatch_count(mc[0]),
        .first_fail(ff[0]), .pass(pass_o[0])
    );

    comb_sweep_ctrl #(.SETTLE_CYCLES(3), .EXPECTED(GOLD)) u1 (
        .clk(clk), .rst(rst), .start(start), .y(y[1]),
        .abc(abc[1]), .busy(busy[1]), .done(done[1]),
        .result(res[1]), .mismatch_count(mc[1]),
        .first_fail(ff[1]), .pass(pass_o[1])
    );

    function automatic int per(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: sweep position follows from edges elapsed since accept
    always @(posedge clk or posedge rst) begin
        int p;
        int i;
        for (int k = 0; k < 2; k++) begin
            if (rst || (!m_act[k] && start)) begin
                m_act[k]  = !rst;
                m_e[k]    = 0;
                m_abc[k]  = 3'd0;
                m_res[k]  = 8'd0;
                m_cnt[k]  = 4'd0;
                m_ff[k]   = 3'd0;
                m_pass[k] = 1'b0;
            end else if (m_act[k]) begin
                p = per(k);
                m_e[k]++;
                if ((m_e[k] % p == 0) && (m_e[k] <= 8 * p)) begin
                    i = m_e[k] / p - 1;
                    m_res[k][i] = tbl[k][i];
                    if (tbl[k][i] != exp_tt[i]) begin
                        if (m_cnt[k] == 4'd0) m_ff[k] = 3'(i);
                        m_cnt[k] = m_cnt[k] + 4'd1;
                    end
                    if (i == 7) m_pass[k] = (m_cnt[k] == 4'd0);
                    m_abc[k] = 3'((i == 7) ? 7 : i + 1);
                end
                if (m_e[k] == 8 * p + 1) m_act[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("cycle_u%0d", k),
                    {abc[k], busy[k], done[k], res[k], mc[k], pass_o[k]},
                    {m_abc[k], m_act[k] && (m_e[k] < 8 * per(k)),
                     m_act[k] && (m_e[k] == 8 * per(k)),
                     m_res[k], m_cnt[k], m_pass[k]});
                if (m_cnt[k] != 4'd0)
                    chk($sformatf("first_fail_u%0d", k), ff[k], m_ff[k]);
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        start = 1'b0;
        while ((m_act[0] || m_act[1]) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(m_act[0] || m_act[1]), 0);
    endtask

    task automatic sweep(input int k, input bit noisy, output int n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        if (busy[k]) hold[abc[k]]++;
        while (!done[k] && n < 100) begin
            @(negedge clk);
            n++;
            if (noisy) start = 1'($urandom_range(0, 1));
            if (busy[k]) hold[abc[k]]++;
        end
        start = 1'b0;
    endtask

    initial begin
        int n;
        int dn;
        int bl;
        int d1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk("reset_state",
                {abc[k], busy[k], done[k], res[k], mc[k], ff[k], pass_o[k]}, 0);
        rst = 1'b0;

        sweep(0, 0, n);
        chk("gold_latency", n, 16);
        chk("gold_result", res[0], 8'h12);
        chk("gold_mc", mc[0], 0);
        chk("gold_pass", pass_o[0], 1);

        wait_idle();
        tbl[0] = 8'h00;
        sweep(0, 0, n);
        chk("stuck0_result", res[0], 8'h00);
        chk("stuck0_mc", mc[0], 2);
        chk("stuck0_ff", ff[0], 1);
        chk("stuck0_pass", pass_o[0], 0);

        wait_idle();
        tbl[0] = 8'hF0;
        sweep(0, 0, n);
        chk("ya_result", res[0], 8'hF0);
        chk("ya_mc", mc[0], 4);
        chk("ya_ff", ff[0], 1);
        chk("ya_pass", pass_o[0], 0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ya_held", {res[0], mc[0], pass_o[0]}, {8'hF0, 4'd4, 1'b0});

        tbl[0] = 8'h12;
        tbl[1] = 8'h12;
        for (int v = 0; v < 8; v++) hold[v] = 0;
        sweep(1, 1, n);
        chk("s3_latency", n, 32);
        chk("s3_result", res[1], 8'h12);
        chk("s3_pass", pass_o[1], 1);
        for (int v = 0; v < 8; v++)
            chk($sformatf("s3_hold_abc%0d", v), hold[v], 4);

        wait_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_abc", abc[0], 4);
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++)
            chk("async_rst",
                {abc[k], busy[k], done[k], res[k], mc[k], ff[k], pass_o[k]}, 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            dn += int'(done[0]) + int'(done[1]);
        end
        chk("no_done_after_abort", dn, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sweep(0, 0, n);
        chk("post_rst_latency", n, 16);
        chk("post_rst_result", res[0], 8'h12);
        chk("post_rst_pass", pass_o[0], 1);

        wait_idle();
        start = 1'b1;
        dn = 0;
        bl = 0;
        d1 = 0;
        for (int j = 1; j <= 54; j++) begin
            @(negedge clk);
            dn += int'(done[0]);
            bl += int'(!busy[0]);
            d1 += int'(done[1]);
        end
        start = 1'b0;
        chk("held_done_u0", dn, 3);
        chk("held_busy_low_u0", bl, 6);
        chk("held_done_u1", d1, 1);

        wait_idle();
        repeat (1500) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0)
                tbl[$urandom_range(0, 1)] = 8'($urandom);
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
